addsub_seq_unit: RTL and testbench

Parametrised multi-cycle integer add/subtract unit, successor to the 32-bit combinational unsigned adder in the ALU arithmetic unit.
- Processes operands CHUNK bits per clock with a rippled carry, so WIDTH can grow without a long combinational carry chain.
- Produces sum plus carry, signed-overflow and zero flags.
- Sits between the ALU operand registers and the result mux; the controller drives it via a start/busy/done handshake.

---
 rtl/addsub_seq_unit_if.sv | 27 ++
 rtl/addsub_seq_unit.sv | 166 ++++++++++++++++
 tb/tb_addsub_seq_unit.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/addsub_seq_unit_if.sv
// Start/busy/done handshake and operand/result bus for addsub_seq_unit.
// The controller drives through the master modport and the unit answers through the slave modport.
interface addsub_seq_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] out;
  logic             carry_out;
  logic             overflow;
  logic             zero;
  logic             sat;

  modport master (
    output start, sub, A, B,
    input  busy, done, out, carry_out, overflow, zero, sat
  );

  modport slave (
    input  start, sub, A, B,
    output busy, done, out, carry_out, overflow, zero, sat
  );
endinterface

// File: rtl/addsub_seq_unit.sv
// Multi-cycle add/subtract: CHUNK bits per clock with a rippled carry, plus carry/overflow/zero flags.
// Defining ADDU_SAT_EN enables unsigned saturation; without it the sat output stays 0.
module addsub_seq_unit #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic              clk,
  input  logic              rst,
  addsub_seq_unit_if.slave  bus
);
  localparam int NCH = WIDTH / CHUNK;
  localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [0:0] {IDLE = 1'b0, RUN = 1'b1} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             carry_out_q, carry_out_d;
  logic             overflow_q, overflow_d;
  logic             zero_q, zero_d;
  logic             sat_q, sat_d;
`ifdef ADDU_SAT_EN
  logic             sub_q, sub_d;
`endif

  logic [CHUNK-1:0] a_chunk_s;
  logic [CHUNK-1:0] b_chunk_s;
  logic [CHUNK:0]   sum_s;
  logic [WIDTH-1:0] final_s;
  logic             last_s;

  assign a_chunk_s = opa_q[cnt_q*CHUNK +: CHUNK];
  assign b_chunk_s = opb_q[cnt_q*CHUNK +: CHUNK];
  assign sum_s     = {1'b0, a_chunk_s} + {1'b0, b_chunk_s} + {{CHUNK{1'b0}}, carry_q};
  assign last_s    = (cnt_q == CW'(NCH - 1));

  // Next-state, datapath and output flag computation.
  always_comb begin
    state_d     = state_q;
    opa_d       = opa_q;
    opb_d       = opb_q;
    work_d      = work_q;
    out_d       = out_q;
    cnt_d       = cnt_q;
    carry_d     = carry_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    carry_out_d = carry_out_q;
    overflow_d  = overflow_q;
    zero_d      = zero_q;
    sat_d       = sat_q;
    final_s     = '0;
`ifdef ADDU_SAT_EN
    sub_d       = sub_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          // Subtraction is A + ~B + 1: the +1 enters as the initial carry.
          opa_d   = bus.A;
          opb_d   = bus.sub ? ~bus.B : bus.B;
          carry_d = bus.sub;
          cnt_d   = '0;
          work_d  = '0;
          busy_d  = 1'b1;
          state_d = RUN;
`ifdef ADDU_SAT_EN
          sub_d   = bus.sub;
`endif
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        work_d[cnt_q*CHUNK +: CHUNK] = sum_s[CHUNK-1:0];
        carry_d = sum_s[CHUNK];
        if (last_s) begin
          state_d     = IDLE;
          busy_d      = 1'b0;
          done_d      = 1'b1;
          cnt_d       = '0;
          carry_out_d = sum_s[CHUNK];
          overflow_d  = (a_chunk_s[CHUNK-1] == b_chunk_s[CHUNK-1]) &&
                        (sum_s[CHUNK-1] != a_chunk_s[CHUNK-1]);
`ifdef ADDU_SAT_EN
          if (!sub_q && sum_s[CHUNK]) begin
            final_s = '1;
            sat_d   = 1'b1;
          end else if (sub_q && !sum_s[CHUNK]) begin
            final_s = '0;
            sat_d   = 1'b1;
          end else begin
            final_s = work_d;
            sat_d   = 1'b0;
          end
`else
          final_s = work_d;
          sat_d   = 1'b0;
`endif
          out_d  = final_s;
          zero_d = (final_s == '0);
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      opa_q       <= '0;
      opb_q       <= '0;
      work_q      <= '0;
      out_q       <= '0;
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      carry_out_q <= 1'b0;
      overflow_q  <= 1'b0;
      zero_q      <= 1'b0;
      sat_q       <= 1'b0;
`ifdef ADDU_SAT_EN
      sub_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      opa_q       <= opa_d;
      opb_q       <= opb_d;
      work_q      <= work_d;
      out_q       <= out_d;
      cnt_q       <= cnt_d;
      carry_q     <= carry_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      carry_out_q <= carry_out_d;
      overflow_q  <= overflow_d;
      zero_q      <= zero_d;
      sat_q       <= sat_d;
`ifdef ADDU_SAT_EN
      sub_q       <= sub_d;
`endif
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.out       = out_q;
  assign bus.carry_out = carry_out_q;
  assign bus.overflow  = overflow_q;
  assign bus.zero      = zero_q;
  assign bus.sat       = sat_q;
endmodule

// File: tb/tb_addsub_seq_unit.sv
// Directed-vector bench for addsub_seq_unit (WIDTH=32, CHUNK=8); expectations follow ADDU_SAT_EN.
module tb_addsub_seq_unit;
  logic clk;
  logic rst;
  int   checks;
  int   failures;
  int   lat;
  int   dones;

  addsub_seq_unit_if #(.WIDTH(32)) bus ();

  addsub_seq_unit #(.WIDTH(32), .CHUNK(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one operation and wait (bounded) for done; lat = edges after the accepting edge.
  task automatic run_op(input logic s, input logic [31:0] a, input logic [31:0] b, output int n);
    bus.start = 1'b1;
    bus.sub   = s;
    bus.A     = a;
    bus.B     = b;
    tick();
    bus.start = 1'b0;
    bus.A     = 32'hDEAD_BEEF;
    bus.B     = 32'h1234_5678;
    n = 0;
    while (bus.done !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.sub   = 1'b0;
    bus.A     = 32'h0;
    bus.B     = 32'h0;
    tick();
    tick();
    check("rst_busy", {31'b0, bus.busy}, 32'd0);
    check("rst_done", {31'b0, bus.done}, 32'd0);
    check("rst_out", bus.out, 32'h0);
    check("rst_flags", {28'b0, bus.carry_out, bus.overflow, bus.zero, bus.sat}, 32'h0);
    rst = 1'b0;
    tick();

    // FFFFFFFF + 1 wraps to zero with carry.
    run_op(1'b0, 32'hFFFF_FFFF, 32'h0000_0001, lat);
    check("add_wrap_lat", lat, 32'd4);
    check("add_wrap_out", bus.out, 32'h0);
    check("add_wrap_flags", {29'b0, bus.carry_out, bus.overflow, bus.zero}, 32'b101);
    check("add_wrap_busy", {31'b0, bus.busy}, 32'd0);
    tick();
    check("done_one_cycle", {31'b0, bus.done}, 32'd0);

    run_op(1'b1, 32'h0000_0005, 32'h0000_0007, lat);
    check("sub57_lat", lat, 32'd4);
`ifdef ADDU_SAT_EN
    check("sub57_out", bus.out, 32'h0);
    check("sub57_flags", {28'b0, bus.carry_out, bus.overflow, bus.zero, bus.sat}, 32'b0011);
`else
    check("sub57_out", bus.out, 32'hFFFF_FFFE);
    check("sub57_flags", {28'b0, bus.carry_out, bus.overflow, bus.zero, bus.sat}, 32'b0000);
`endif
    tick();

    run_op(1'b0, 32'h7FFF_FFFF, 32'h0000_0001, lat);
    check("add_ovf_out", bus.out, 32'h8000_0000);
    check("add_ovf_flags", {29'b0, bus.carry_out, bus.overflow, bus.zero}, 32'b010);
    tick();

    run_op(1'b1, 32'h8000_0000, 32'h0000_0001, lat);
    check("sub_ovf_out", bus.out, 32'h7FFF_FFFF);
    check("sub_ovf_flags", {29'b0, bus.carry_out, bus.overflow, bus.zero}, 32'b110);
    tick();

    // Start held high for cycles 1-3 while busy must be ignored.
    bus.start = 1'b1;
    bus.sub   = 1'b0;
    bus.A     = 32'h0000_0001;
    bus.B     = 32'h0000_0002;
    tick();
    bus.A     = 32'h0000_1000;
    bus.B     = 32'h0000_2000;
    dones = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (bus.done === 1'b1) dones++;
    end
    bus.start = 1'b0;
    check("ignored_no_early_done", dones, 32'd0);
    tick();
    check("ignored_done", {31'b0, bus.done}, 32'd1);
    check("ignored_out", bus.out, 32'h0000_0003);

    // Back-to-back: start during the done cycle is accepted.
    bus.start = 1'b1;
    bus.A     = 32'h0000_0100;
    bus.B     = 32'h0000_0200;
    tick();
    bus.start = 1'b0;
    check("b2b_done_falls", {31'b0, bus.done}, 32'd0);
    check("b2b_busy", {31'b0, bus.busy}, 32'd1);
    check("b2b_out_held", bus.out, 32'h0000_0003);
    lat = 0;
    while (bus.done !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
    check("b2b_lat", lat, 32'd4);
    check("b2b_out", bus.out, 32'h0000_0300);
    tick();

    // Reset two cycles into an add aborts it.
    bus.start = 1'b1;
    bus.sub   = 1'b0;
    bus.A     = 32'h1234_0000;
    bus.B     = 32'h0000_5678;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_busy", {31'b0, bus.busy}, 32'd0);
    check("abort_done", {31'b0, bus.done}, 32'd0);
    check("abort_out", bus.out, 32'h0);
    dones = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (bus.done === 1'b1) dones++;
    end
    check("abort_no_done", dones, 32'd0);

    run_op(1'b0, 32'h0000_0010, 32'h0000_0020, lat);
    check("post_abort_lat", lat, 32'd4);
    check("post_abort_out", bus.out, 32'h0000_0030);
    tick();

    run_op(1'b0, 32'hFFFF_FFF0, 32'h0000_0020, lat);
`ifdef ADDU_SAT_EN
    check("sat_add_out", bus.out, 32'hFFFF_FFFF);
    check("sat_add_flags", {29'b0, bus.carry_out, bus.sat, bus.zero}, 32'b110);
`else
    check("sat_add_out", bus.out, 32'h0000_0010);
    check("sat_add_flags", {29'b0, bus.carry_out, bus.sat, bus.zero}, 32'b100);
`endif
    tick();

    run_op(1'b1, 32'h0000_0003, 32'h0000_0005, lat);
`ifdef ADDU_SAT_EN
    check("sat_sub_out", bus.out, 32'h0);
    check("sat_sub_flags", {29'b0, bus.carry_out, bus.sat, bus.zero}, 32'b011);
`else
    check("sat_sub_out", bus.out, 32'hFFFF_FFFE);
    check("sat_sub_flags", {29'b0, bus.carry_out, bus.sat, bus.zero}, 32'b000);
`endif
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
